thermal_frame_reader: RTL and testbench

- Display-side read stage for the double-buffered thermal frame RAM (simple dual-port, 1-cycle registered read).
- Takes raster timing from the video timing generator and issues RAM reads for the current display bank.
- Upscales the 32x24 sensor frame by integer replication and emits pixel data aligned with delayed syncs to the palette/TMDS stage.
- Swaps banks only at frame boundaries, on request from the frame writer.

---
 rtl/thermal_frame_reader.sv | 138 +++++++++++++
 tb/tb_thermal_frame_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_frame_reader.sv
// Display-side read stage for the double-buffered thermal frame RAM.
// Replicates each sensor pixel SCALE times per axis and aligns pixel data with delayed syncs.
module thermal_frame_reader #(
  parameter int PIX_W = 16,
  parameter int SRC_W = 32,
  parameter int SRC_H = 24,
  parameter int SCALE = 20,
  localparam int FRAME_WORDS = SRC_W * SRC_H,
  localparam int ADDRW = $clog2(2 * FRAME_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_de,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_bank_ready,
  output logic             o_rd_req,
  output logic [ADDRW-1:0] o_rd_addr,
  input  logic [PIX_W-1:0] i_rd_data,
  output logic [PIX_W-1:0] o_pixel,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_bank
);

  localparam int XW = $clog2(SCALE);
  localparam int CW = $clog2(SRC_W + 1);
  localparam int RW = $clog2(SRC_H + 1);

  logic [XW-1:0]    r_xsub;
  logic [XW-1:0]    r_ysub;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [ADDRW-1:0] r_row_base;
  logic             r_armed;
  logic             r_bank;
  logic             r_swap_pending;
  logic             r_rd_req;
  logic [ADDRW-1:0] r_rd_addr;
  logic             r_req_d;
  logic [PIX_W-1:0] r_pixel;
  logic [2:0]       r_de_pipe;
  logic [2:0]       r_hs_pipe;
  logic [2:0]       r_vs_pipe;

  logic             w_vs_rise;
  logic             w_de_fall;
  logic             w_in_range;
  logic [ADDRW-1:0] w_addr;

  assign w_vs_rise  = i_vsync & ~r_vs_pipe[0];
  assign w_de_fall  = r_de_pipe[0] & ~i_de;
  // r_armed keeps a mid-frame reset from reading with bogus counters until a fresh frame starts
  assign w_in_range = r_armed & i_de & (r_col < CW'(SRC_W)) & (r_row < RW'(SRC_H));
  assign w_addr     = (r_bank ? ADDRW'(FRAME_WORDS) : ADDRW'(0)) + r_row_base + ADDRW'(r_col);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xsub     <= '0;
      r_ysub     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_armed    <= 1'b0;
    end else if (w_vs_rise) begin
      r_xsub     <= '0;
      r_ysub     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_armed    <= 1'b1;
    end else if (w_de_fall) begin
      r_xsub <= '0;
      r_col  <= '0;
      if (r_ysub == XW'(SCALE - 1)) begin
        r_ysub <= '0;
        if (r_row < RW'(SRC_H)) begin
          r_row      <= r_row + RW'(1);
          r_row_base <= r_row_base + ADDRW'(SRC_W);
        end
      end else begin
        r_ysub <= r_ysub + XW'(1);
      end
    end else if (i_de) begin
      if (r_xsub == XW'(SCALE - 1)) begin
        r_xsub <= '0;
        if (r_col < CW'(SRC_W)) r_col <= r_col + CW'(1);
      end else begin
        r_xsub <= r_xsub + XW'(1);
      end
    end
  end

  // A ready pulse coincident with the vsync rise swaps immediately rather than waiting a frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank         <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_vs_rise) begin
      if (r_swap_pending | i_bank_ready) begin
        r_bank         <= ~r_bank;
        r_swap_pending <= 1'b0;
      end
    end else if (i_bank_ready) begin
      r_swap_pending <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_req_d   <= 1'b0;
      r_pixel   <= '0;
      r_de_pipe <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
    end else begin
      r_rd_req <= w_in_range;
      if (w_in_range) r_rd_addr <= w_addr;
      r_req_d   <= r_rd_req;
      r_pixel   <= r_req_d ? i_rd_data : '0;
      r_de_pipe <= {r_de_pipe[1:0], i_de};
      r_hs_pipe <= {r_hs_pipe[1:0], i_hsync};
      r_vs_pipe <= {r_vs_pipe[1:0], i_vsync};
    end
  end

  assign o_rd_req  = r_rd_req;
  assign o_rd_addr = r_rd_addr;
  assign o_pixel   = r_pixel;
  assign o_de      = r_de_pipe[2];
  assign o_hsync   = r_hs_pipe[2];
  assign o_vsync   = r_vs_pipe[2];
  assign o_bank    = r_bank;

endmodule

// File: tb/tb_thermal_frame_reader.sv
// Directed bench for thermal_frame_reader: per-line table vectors, a per-cycle line model,
// and hand sequences for bank swaps, sync delay and mid-frame reset.
module tb_thermal_frame_reader;

  localparam int PIX_W = 16;
  localparam int ADDRW = 11;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_de = 1'b0;
  logic             i_hsync = 1'b0;
  logic             i_vsync = 1'b0;
  logic             i_bank_ready = 1'b0;
  logic             o_rd_req;
  logic [ADDRW-1:0] o_rd_addr;
  logic [PIX_W-1:0] i_rd_data;
  logic [PIX_W-1:0] o_pixel;
  logic             o_de;
  logic             o_hsync;
  logic             o_vsync;
  logic             o_bank;
  logic [PIX_W-1:0] ram_q = '0;

  thermal_frame_reader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_de(i_de), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_bank_ready(i_bank_ready), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .o_pixel(o_pixel), .o_de(o_de), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_bank(o_bank)
  );

  always #5 i_clk = ~i_clk;

  // RAM model: word[a] = a, one-cycle registered read
  always @(posedge i_clk) if (o_rd_req) ram_q <= PIX_W'(o_rd_addr);
  assign i_rd_data = ram_q;

  typedef struct {
    int scen;
    int k;
    bit req;
    int addr;
    int pix;
    bit de;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   obs_req[0:1023];
  int   obs_addr[0:1023];
  int   obs_pix[0:1023];
  bit   obs_de[0:1023];
  bit   obs_hs[0:1023];
  bit   hs_in[0:1023];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_line(input int len_de, input int total);
    for (int k = 0; k < total; k++) begin
      i_de    = (k < len_de);
      i_hsync = (k % 7 == 0);
      hs_in[k] = i_hsync;
      step();
      obs_req[k]  = o_rd_req;
      obs_addr[k] = int'(o_rd_addr);
      obs_pix[k]  = int'(o_pixel);
      obs_de[k]   = o_de;
      obs_hs[k]   = o_hsync;
    end
    i_de    = 1'b0;
    i_hsync = 1'b0;
  endtask

  task automatic short_lines(input int n);
    repeat (n) run_line(5, 8);
  endtask

  // Independent per-cycle model of one line starting at col 0 with the given source base address
  task automatic check_line(input string name, input int base, input bit readable,
                            input int len_de, input int total);
    int n_rd, errs, first_k;
    bit e_req, e_de;
    int e_pix;
    n_rd = readable ? ((len_de < 640) ? len_de : 640) : 0;
    errs = 0;
    first_k = -1;
    for (int k = 0; k < total; k++) begin
      e_req = (k < n_rd);
      e_pix = (k >= 2 && (k - 2) < n_rd) ? base + (k - 2) / 20 : 0;
      e_de  = (k >= 2 && (k - 2) < len_de);
      if (obs_req[k] != e_req || (e_req && obs_addr[k] != base + k / 20) ||
          obs_pix[k] != e_pix || obs_de[k] != e_de || (k >= 2 && obs_hs[k] != hs_in[k - 2])) begin
        errs++;
        if (first_k < 0) first_k = k;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first k=%0d req=%0b addr=%0d pix=%0d de=%0b hs=%0b",
               name, errs, first_k, obs_req[first_k], obs_addr[first_k], obs_pix[first_k],
               obs_de[first_k], obs_hs[first_k]);
    end
  endtask

  task automatic check_table(input int s);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].scen == s) begin
        int k;
        k = tbl[i].k;
        n_tests++;
        if (obs_req[k] != tbl[i].req || obs_addr[k] != tbl[i].addr ||
            obs_pix[k] != tbl[i].pix || obs_de[k] != tbl[i].de) begin
          n_fail++;
          $display("FAIL vec s%0d k%0d: got req=%0b addr=%0d pix=%0d de=%0b expected req=%0b addr=%0d pix=%0d de=%0b",
                   s, k, obs_req[k], obs_addr[k], obs_pix[k], obs_de[k],
                   tbl[i].req, tbl[i].addr, tbl[i].pix, tbl[i].de);
        end
      end
    end
  endtask

  // One-cycle vsync pulse with optional coincident bank_ready; checks o_vsync delay and bank result
  task automatic vsync_pulse(input string name, input bit rdy, input int exp_bank_before,
                             input int exp_bank_after);
    logic [4:0] vs_seen;
    chk({name, "_bank_before"}, int'(o_bank), exp_bank_before);
    i_vsync = 1'b1;
    i_bank_ready = rdy;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) chk({name, "_bank_after"}, int'(o_bank), exp_bank_after);
      i_vsync = 1'b0;
      i_bank_ready = 1'b0;
      vs_seen[j] = o_vsync;
    end
    chk({name, "_vsync_delay"}, int'(vs_seen), 5'b00100);
  endtask

  initial begin
    tbl.push_back('{0,   0, 1'b1,  0,  0, 1'b0});
    tbl.push_back('{0,  19, 1'b1,  0,  0, 1'b1});
    tbl.push_back('{0,  20, 1'b1,  1,  0, 1'b1});
    tbl.push_back('{0,  22, 1'b1,  1,  1, 1'b1});
    tbl.push_back('{0, 639, 1'b1, 31, 31, 1'b1});
    tbl.push_back('{0, 640, 1'b0, 31, 31, 1'b1});
    tbl.push_back('{0, 641, 1'b0, 31, 31, 1'b1});
    tbl.push_back('{0, 642, 1'b0, 31,  0, 1'b0});
    tbl.push_back('{1,   0, 1'b1, 32,  0, 1'b0});
    tbl.push_back('{1,   2, 1'b1, 32, 32, 1'b1});
    tbl.push_back('{1, 639, 1'b1, 63, 63, 1'b1});
    tbl.push_back('{1, 641, 1'b0, 63, 63, 1'b1});
    tbl.push_back('{1, 642, 1'b0, 63,  0, 1'b0});
    tbl.push_back('{2,   0, 1'b0, 736, 0, 1'b0});
    tbl.push_back('{2,   2, 1'b0, 736, 0, 1'b1});
    tbl.push_back('{2, 300, 1'b0, 736, 0, 1'b1});
    tbl.push_back('{2, 641, 1'b0, 736, 0, 1'b1});
    tbl.push_back('{3, 639, 1'b1, 31, 31, 1'b1});
    tbl.push_back('{3, 640, 1'b0, 31, 31, 1'b1});
    tbl.push_back('{3, 642, 1'b0, 31,  0, 1'b1});
    tbl.push_back('{3, 700, 1'b0, 31,  0, 1'b1});
    tbl.push_back('{3, 799, 1'b0, 31,  0, 1'b1});
    tbl.push_back('{3, 801, 1'b0, 31,  0, 1'b1});
    tbl.push_back('{3, 802, 1'b0, 31,  0, 1'b0});
    tbl.push_back('{4,   0, 1'b1, 768,   0, 1'b0});
    tbl.push_back('{4,   2, 1'b1, 768, 768, 1'b1});
    tbl.push_back('{4, 639, 1'b1, 799, 799, 1'b1});

    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_rd_req", int'(o_rd_req), 0);
    chk("rst_rd_addr", int'(o_rd_addr), 0);
    chk("rst_pixel", int'(o_pixel), 0);
    chk("rst_de", int'(o_de), 0);
    chk("rst_bank", int'(o_bank), 0);
    step();
    step();
    i_rst_n = 1'b1;
    repeat (3) step();

    vsync_pulse("vs0", 1'b0, 0, 0);
    run_line(640, 645);
    check_table(0);
    check_line("line0", 0, 1'b1, 640, 645);
    short_lines(19);
    run_line(640, 645);
    check_table(1);
    check_line("line20", 32, 1'b1, 640, 645);
    short_lines(459);
    run_line(640, 645);
    check_table(2);
    check_line("line480", 0, 1'b0, 640, 645);

    vsync_pulse("vs1", 1'b0, 0, 0);
    run_line(800, 805);
    check_table(3);
    check_line("line800", 0, 1'b1, 800, 805);

    i_bank_ready = 1'b1;
    step();
    i_bank_ready = 1'b0;
    repeat (3) step();
    i_bank_ready = 1'b1;
    step();
    i_bank_ready = 1'b0;
    step();
    chk("bank_held_midframe", int'(o_bank), 0);
    vsync_pulse("vs_swap", 1'b0, 0, 1);
    run_line(640, 645);
    check_table(4);
    check_line("bank1_line", 768, 1'b1, 640, 645);
    vsync_pulse("vs_coincident", 1'b1, 1, 0);
    run_line(40, 45);
    i_bank_ready = 1'b1;
    step();
    i_bank_ready = 1'b0;
    repeat (2) step();
    chk("bank_pending_held", int'(o_bank), 0);
    vsync_pulse("vs_swap_back", 1'b0, 0, 1);
    vsync_pulse("vs_no_pending", 1'b0, 1, 1);

    i_de = 1'b1;
    repeat (100) step();
    #3 i_rst_n = 1'b0;
    #1;
    chk("async_rst_rd_req", int'(o_rd_req), 0);
    chk("async_rst_rd_addr", int'(o_rd_addr), 0);
    chk("async_rst_pixel", int'(o_pixel), 0);
    chk("async_rst_de", int'(o_de), 0);
    chk("async_rst_bank", int'(o_bank), 0);
    step();
    step();
    i_rst_n = 1'b1;
    repeat (10) step();
    i_de = 1'b0;
    repeat (3) step();
    run_line(640, 645);
    check_line("no_read_before_vsync", 0, 1'b0, 640, 645);
    vsync_pulse("vs_after_rst", 1'b0, 0, 0);
    run_line(640, 645);
    check_line("line_after_rst", 0, 1'b1, 640, 645);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
